// File: rtl/qmulti_pkg.sv
// Shared state encoding and format helpers for the iterative sign-magnitude Q multiplier.
package qmulti_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int sign_idx(input int w);
    return w - 1;
  endfunction

  function automatic int mag_w(input int w);
    return w - 1;
  endfunction

  function automatic int acc_w(input int w);
    return 2 * (w - 1);
  endfunction

endpackage

// File: rtl/qmulti_pack.sv
// Turns the raw magnitude product into a packed sign-magnitude word: truncate, saturate, fix sign.
module qmulti_pack
  import qmulti_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic [acc_w(WIDTH)-1:0] acc,
  input  logic                    sign,
  output logic [WIDTH-1:0]        result,
  output logic                    ovf
);

  localparam int MAG_W = mag_w(WIDTH);
  localparam int ACC_W = acc_w(WIDTH);

  function automatic logic [ACC_W-1:0] trunc_shift(input logic [ACC_W-1:0] a);
    return a >> FRAC;
  endfunction

  // Anything left above the magnitude field after the fractional shift cannot be represented.
  function automatic logic sat_detect(input logic [ACC_W-1:0] s);
    return |(s >> MAG_W);
  endfunction

  function automatic logic [MAG_W-1:0] saturate(input logic [MAG_W-1:0] m, input logic o);
    return o ? {MAG_W{1'b1}} : m;
  endfunction

  logic [ACC_W-1:0] shifted;
  logic [MAG_W-1:0] mag;

  always_comb begin
    shifted = trunc_shift(acc);
    ovf     = sat_detect(shifted);
    mag     = saturate(shifted[MAG_W-1:0], ovf);
    result  = {sign & (|mag), mag};
  end

endmodule

// File: rtl/qmulti_iter.sv
// Iterative shift-add sign-magnitude fixed-point multiplier, one multiplier bit per cycle.
module qmulti_iter
  import qmulti_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] multi1,
  input  logic [WIDTH-1:0] multi2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int MAG_W = mag_w(WIDTH);
  localparam int ACC_W = acc_w(WIDTH);
  localparam int SGN   = sign_idx(WIDTH);
  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] mcand;
  logic [MAG_W-1:0] mplier;
  logic             sgn;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] pack_res;
  logic             pack_ovf;

  qmulti_pack #(
    .WIDTH(WIDTH),
    .FRAC (FRAC)
  ) u_pack (
    .acc   (acc),
    .sign  (sgn),
    .result(pack_res),
    .ovf   (pack_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      sgn       <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mcand    <= ACC_W'(multi1[MAG_W-1:0]);
            mplier   <= multi2[MAG_W-1:0];
            sgn      <= multi1[SGN] ^ multi2[SGN];
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Count reaches WIDTH-1 once every magnitude bit is in; this extra cycle registers the packed result.
          if (cnt == CNT_W'(WIDTH - 1)) begin
            result    <= pack_res;
            ovf       <= pack_ovf;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            if (mplier[0]) begin
              acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qmulti_iter.sv
// Scoreboard bench for qmulti_iter: directed operand pairs with hand-computed products.
module tb_qmulti_iter;

  localparam int LAT = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] multi1 = '0;
  logic [31:0] multi2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        ovf;

  qmulti_iter #(.WIDTH(32), .FRAC(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .multi1   (multi1),
    .multi2   (multi2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   seen  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r, input logic exp_o, output int acc_cyc);
    exp_t e;
    multi1   = a;
    multi2   = b;
    in_valid = 1'b1;
    acc_cyc  = -1;
    for (int k = 0; k < 100; k++) begin
      if (in_ready === 1'b1) begin
        acc_cyc = cyc + 1;
        e.res = exp_r;
        e.ovf = exp_o;
        e.acc = acc_cyc;
        sb.push_back(e);
        step();
        break;
      end
      step();
    end
    in_valid = 1'b0;
    multi1   = $urandom;
    multi2   = $urandom;
    if (acc_cyc < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: operands 0x%0h x 0x%0h never accepted", a, b);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb.size() > 0; k++) step();
    if (sb.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d results pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got result 0x%0h, want no output", result);
      end else begin
        check("result", result, sb[0].res);
        check("ovf", ovf, sb[0].ovf);
        check("in_ready_in_done", in_ready, 0);
        if (!seen) check("latency", cyc - sb[0].acc, LAT);
        seen = 1'b1;
        if (out_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    int acc_c;
    int c;
    bit got;

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_ovf", ovf, 0);
    step();
    step();
    rst_n = 1'b1;

    issue(32'h0004_0000, 32'h0004_0000, 32'h0010_0000, 1'b0, acc_c);
    issue(32'h0004_8000, 32'h0004_8000, 32'h0014_4000, 1'b0, acc_c);
    issue(32'h8005_8000, 32'h8005_8000, 32'h001E_4000, 1'b0, acc_c);
    issue(32'h8005_8000, 32'h0005_8000, 32'h801E_4000, 1'b0, acc_c);
    issue(32'h7FFF_0000, 32'h0002_0000, 32'h7FFF_FFFF, 1'b1, acc_c);
    issue(32'h7FFF_0000, 32'h0001_0000, 32'h7FFF_0000, 1'b0, acc_c);
    issue(32'h8000_0000, 32'h0005_0000, 32'h0000_0000, 1'b0, acc_c);
    issue(32'h0000_0000, 32'h8003_0000, 32'h0000_0000, 1'b0, acc_c);
    issue(32'h8000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0, acc_c);
    issue(32'h0001_8000, 32'h8000_0002, 32'h8000_0003, 1'b0, acc_c);
    drain();

    // Consumer stall: result held for 10 cycles, then handoff and back-to-back acceptance.
    out_ready = 1'b0;
    issue(32'h0003_0000, 32'h0002_0000, 32'h0006_0000, 1'b0, acc_c);
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (out_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      step();
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL stall_wait: got no out_valid, want out_valid within 100 cycles");
    end
    for (int k = 0; k < 10; k++) step();
    out_ready = 1'b1;
    c = cyc;
    issue(32'h0002_0000, 32'h0002_0000, 32'h0004_0000, 1'b0, acc_c);
    check("accept_after_handoff", acc_c, c + 2);
    drain();

    // Reset in the middle of BUSY discards the operation.
    issue(32'h0004_0000, 32'h0004_0000, 32'h0010_0000, 1'b0, acc_c);
    for (int k = 0; k < 9; k++) step();
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_in_ready", in_ready, 1);
    check("midreset_result", result, 0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) step();
    issue(32'h0004_8000, 32'h0004_8000, 32'h0014_4000, 1'b0, acc_c);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/qmulti_iter.md
QMULTI_ITER -- requirements
Module: qmulti_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: total word width, sign-magnitude, bit WIDTH-1 = sign.
REQ-002 SHALL have parameter FRAC, default 16: fractional bits, giving format Q(WIDTH-1-FRAC).FRAC.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand pair present.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port multi1  input  WIDTH  multiplicand, sign-magnitude.
REQ-008 SHALL have port multi2  input  WIDTH  multiplier, sign-magnitude.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  WIDTH  product, sign-magnitude.
REQ-012 SHALL have port ovf  output  1  product magnitude saturated; qualified by out_valid.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 SHALL assert in_ready only in IDLE, and out_valid only in DONE.
REQ-015 In IDLE with in_valid=1: SHALL latch both magnitudes and sign = multi1[WIDTH-1] XOR multi2[WIDTH-1], clear the 2*(WIDTH-1)-bit accumulator, clear the bit counter, and enter BUSY.
REQ-016 In BUSY: SHALL process one multiplier magnitude bit per cycle, LSB first (shift-add), for exactly WIDTH-1 cycles, then enter DONE.
REQ-017 SHALL raise out_valid exactly WIDTH cycles after the accepting edge (32 for default parameters).
REQ-018 SHALL form the result magnitude as accumulator >> FRAC, truncated toward zero; no rounding.
REQ-019 If any accumulator bit at or above position FRAC+WIDTH-1 is set: SHALL saturate the magnitude to all ones (WIDTH-1 bits) and set ovf=1; otherwise ovf=0.
REQ-020 If the final magnitude is zero: SHALL force the result sign bit to 0 (no negative zero).
REQ-021 In DONE: SHALL hold result and ovf stable while out_ready=0; with out_ready=1, SHALL enter IDLE on that edge.
REQ-022 SHALL not accept new operands in the same cycle as a DONE handoff; the next acceptance occurs earliest one cycle later, in IDLE.
REQ-023 SHALL ignore multi1, multi2 and in_valid changes while in BUSY or DONE.
REQ-024 SHALL treat operands of ±0 (either sign) as zero and produce result 0, ovf 0.

Reset
REQ-025 On rst_n=0, SHALL immediately, without waiting for clk, force the state to IDLE, in_ready=1, out_valid=0, result=0, ovf=0, and clear the accumulator and counter.
REQ-026 Reset asserted mid-BUSY or in DONE SHALL abort the operation; the partial result is discarded and never presented.
REQ-027 After reset release, SHALL accept operands at the first rising edge with in_valid=1.

Structure
REQ-028 SHALL take state encoding (IDLE/BUSY/DONE) and the format helper constants (sign-bit index, magnitude width WIDTH-1, accumulator width 2*(WIDTH-1)) from shared package qmulti_pkg.
REQ-029 SHALL place truncate, saturate and sign packing in one combinational sub-module qmulti_pack, parameterised by WIDTH and FRAC.
REQ-030 SHALL use no hardware multiplier operator; the datapath is adder plus shifters only.

Verification
REQ-031 Bench SHALL check: 0x00040000 x 0x00040000 (4.0x4.0) -> result 0x00100000, ovf 0, out_valid 32 cycles after acceptance.
REQ-032 Bench SHALL check: 0x00048000 x 0x00048000 -> 0x00144000; 0x80058000 x 0x80058000 -> 0x001E4000; 0x80058000 x 0x00058000 -> 0x801E4000.
REQ-033 Bench SHALL check: 0x7FFF0000 x 0x00020000 -> result 0x7FFFFFFF, ovf 1.
REQ-034 Bench SHALL check: 0x80000000 x 0x00050000 -> result 0x00000000 (sign cleared), ovf 0.
REQ-035 Bench SHALL check: out_ready held 0 for 10 cycles in DONE -> result stable and in_ready 0 throughout; after release, the next operand pair is accepted one cycle later.
REQ-036 Bench SHALL check: rst_n pulsed low at BUSY cycle 10 -> out_valid 0 and in_ready 1 immediately; the following operation completes with the correct product.
